// File: rtl/blackjack_pkg.sv
// Shared blackjack datapath definitions: requester FSM encoding, widths,
// rank constants and the rank-to-points mapping.
package blackjack_pkg;

   localparam int CARD_W  = 4;
   localparam int TOTAL_W = 5;

   localparam logic [CARD_W-1:0]  ACE       = 4'd1;
   localparam logic [CARD_W-1:0]  KING      = 4'd13;
   localparam logic [TOTAL_W-1:0] BLACKJACK = 5'd21;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ADD  = 2'd2,
      ST_DONE = 2'd3
   } req_state_e;

   // Ace counts 1 here; the optional +10 is applied by the score calculator.
   function automatic logic [TOTAL_W-1:0] card_points(input logic [CARD_W-1:0] rank);
      return (rank > 4'd10) ? 5'd10 : TOTAL_W'(rank);
   endfunction

   function automatic logic rank_valid(input logic [CARD_W-1:0] rank);
      return (rank >= ACE) && (rank <= KING);
   endfunction

endpackage

// File: rtl/hand_score_calc.sv
// Combinational hand evaluation from the hard sum, ace flag and card count.
module hand_score_calc
   import blackjack_pkg::*;
(
   input  logic [TOTAL_W-1:0] hard_sum_i,
   input  logic               ace_i,
   input  logic [3:0]         count_i,
   output logic [TOTAL_W-1:0] hand_total_o,
   output logic               soft_o,
   output logic               bust_o,
   output logic               blackjack_o
);

   always_comb begin
      // One ace may count 11 only while that keeps the hand at or below 21.
      soft_o       = ace_i && (hard_sum_i <= 5'd11);
      hand_total_o = soft_o ? (hard_sum_i + 5'd10) : hard_sum_i;
      bust_o       = hard_sum_i > BLACKJACK;
      blackjack_o  = (count_i == 4'd2) && (hand_total_o == BLACKJACK);
   end

endmodule

// File: rtl/hand_card_requester.sv
// Requests one card per hit from a seed_random generator, waits for SEND,
// and accumulates the hand (hard sum, ace flag, count) with sticky error.
module hand_card_requester
   import blackjack_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_CARDS      = 11
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               hit_i,
   input  logic               new_hand_i,
   input  logic               card_valid_i,
   input  logic [CARD_W-1:0]  card_i,
   output logic               req_card_o,
   output logic               busy_o,
   output logic               card_done_o,
   output logic [TOTAL_W-1:0] hand_total_o,
   output logic               soft_o,
   output logic [3:0]         card_count_o,
   output logic               bust_o,
   output logic               blackjack_o,
   output logic               error_o
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       MAX_COUNT = 4'(MAX_CARDS);

   req_state_e         state_q, state_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [CARD_W-1:0]  card_q, card_d;
   logic [TOTAL_W-1:0] hard_q, hard_d;
   logic               ace_q, ace_d;
   logic [3:0]         count_q, count_d;
   logic               error_q, error_d;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         tmo_q   <= '0;
         card_q  <= '0;
         hard_q  <= '0;
         ace_q   <= 1'b0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         card_q  <= card_d;
         hard_q  <= hard_d;
         ace_q   <= ace_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      card_d  = card_q;
      hard_d  = hard_q;
      ace_d   = ace_q;
      count_d = count_q;
      error_d = error_q;

      if (new_hand_i) begin
         state_d = ST_IDLE;
         tmo_d   = '0;
         card_d  = '0;
         hard_d  = '0;
         ace_d   = 1'b0;
         count_d = '0;
         error_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (hit_i && !bust_o && (count_q < MAX_COUNT) && !error_q) begin
                  state_d = ST_REQ;
                  tmo_d   = '0;
               end
            end
            ST_REQ: begin
               // A response on the final allowed cycle still wins over the timeout.
               if (card_valid_i) begin
                  card_d  = card_i;
                  state_d = ST_ADD;
               end else if (tmo_q == TMO_LAST) begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            ST_ADD: begin
               if (rank_valid(card_q)) begin
                  hard_d  = hard_q + card_points(card_q);
                  ace_d   = ace_q | (card_q == ACE);
                  count_d = count_q + 4'd1;
               end else begin
                  error_d = 1'b1;
               end
               state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign req_card_o   = (state_q == ST_REQ);
   assign busy_o       = (state_q != ST_IDLE);
   assign card_done_o  = (state_q == ST_DONE);
   assign card_count_o = count_q;
   assign error_o      = error_q;

   hand_score_calc u_score (
      .hard_sum_i   (hard_q),
      .ace_i        (ace_q),
      .count_i      (count_q),
      .hand_total_o (hand_total_o),
      .soft_o       (soft_o),
      .bust_o       (bust_o),
      .blackjack_o  (blackjack_o)
   );

endmodule

// File: tb/tb_hand_card_requester.sv
// Bench for hand_card_requester: registered generator model, hand model kept
// as a list of ranks, per-cycle output comparison plus directed scenarios.
module tb_hand_card_requester;

   localparam int TMO = 16;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       hit_i = 1'b0;
   logic       new_hand_i = 1'b0;
   logic       card_valid_i;
   logic [3:0] card_i = 4'd1;
   logic       req_card_o, busy_o, card_done_o, soft_o, bust_o, blackjack_o, error_o;
   logic [4:0] hand_total_o;
   logic [3:0] card_count_o;

   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc = 0;
   bit  gen_silent = 1'b0;

   always #5 clk_i = ~clk_i;

   hand_card_requester #(.TIMEOUT_CYCLES(TMO), .MAX_CARDS(11)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .hit_i        (hit_i),
      .new_hand_i   (new_hand_i),
      .card_valid_i (card_valid_i),
      .card_i       (card_i),
      .req_card_o   (req_card_o),
      .busy_o       (busy_o),
      .card_done_o  (card_done_o),
      .hand_total_o (hand_total_o),
      .soft_o       (soft_o),
      .card_count_o (card_count_o),
      .bust_o       (bust_o),
      .blackjack_o  (blackjack_o),
      .error_o      (error_o)
   );

   // Generator: registered echo of the request, unless told to stay silent.
   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) card_valid_i <= 1'b0;
      else        card_valid_i <= req_card_o && !gen_silent;
   end

   // ---------------- hand model ----------------
   int   m_ranks[$];
   bit   m_active = 1'b0;
   bit   m_silent = 1'b0;
   bit   m_err = 1'b0;
   int   m_k = 0;
   int   m_latched = 0;

   function automatic int m_hard();
      int s = 0;
      foreach (m_ranks[i]) s += (m_ranks[i] > 10) ? 10 : m_ranks[i];
      return s;
   endfunction

   function automatic bit m_ace();
      foreach (m_ranks[i]) if (m_ranks[i] == 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_soft();
      return m_ace() && (m_hard() + 10 <= 21);
   endfunction

   function automatic int m_total();
      return m_soft() ? m_hard() + 10 : m_hard();
   endfunction

   initial begin
      forever begin
         @(posedge clk_i or negedge rst_i);
         if (!rst_i) begin
            m_ranks.delete();
            m_active = 1'b0;
            m_err = 1'b0;
         end else begin
            cyc++;
            if (new_hand_i) begin
               m_ranks.delete();
               m_active = 1'b0;
               m_err = 1'b0;
            end else if (m_active) begin
               if (!m_silent) begin
                  if (cyc == m_k + 2)      m_latched = int'(card_i);
                  else if (cyc == m_k + 3) m_ranks.push_back(m_latched);
                  else if (cyc == m_k + 4) m_active = 1'b0;
               end else if (cyc == m_k + TMO) begin
                  m_err = 1'b1;
                  m_active = 1'b0;
               end
            end else if (hit_i && m_hard() <= 21 && m_ranks.size() < 11 && !m_err) begin
               m_active = 1'b1;
               m_k = cyc;
               m_silent = gen_silent;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk_i);
         chk("req_card", 32'(req_card_o), 32'(m_active && (m_silent || (cyc - m_k) < 2)));
         chk("busy", 32'(busy_o), 32'(m_active));
         chk("card_done", 32'(card_done_o), 32'(m_active && !m_silent && (cyc - m_k) == 3));
         chk("hand_total", 32'(hand_total_o), 32'(m_total()));
         chk("soft", 32'(soft_o), 32'(m_soft()));
         chk("card_count", 32'(card_count_o), 32'(m_ranks.size()));
         chk("bust", 32'(bust_o), 32'(m_hard() > 21));
         chk("blackjack", 32'(blackjack_o), 32'(m_ranks.size() == 2 && m_total() == 21));
         chk("error", 32'(error_o), 32'(m_err));
         if (card_done_o)
            $display("card done: cycle=%0d count=%0d total=%0d soft=%0d bust=%0d bj=%0d",
                     cyc, card_count_o, hand_total_o, soft_o, bust_o, blackjack_o);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_hit(input logic [3:0] r);
      @(negedge clk_i);
      card_i = r;
      hit_i  = 1'b1;
      @(negedge clk_i);
      hit_i  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         #1;
         if (card_done_o) begin
            got = 1'b1;
            break;
         end
      end
      chk(name, 32'(got), 32'd1);
   endtask

   task automatic card(input logic [3:0] r);
      do_hit(r);
      wait_done("done_seen");
   endtask

   task automatic new_hand();
      @(negedge clk_i);
      new_hand_i = 1'b1;
      @(negedge clk_i);
      new_hand_i = 1'b0;
   endtask

   initial begin
      int dones;
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_total", 32'(hand_total_o), 32'd0);
      chk("rst_req", 32'(req_card_o), 32'd0);
      rst_i = 1'b1;

      // Ace + king: blackjack.
      card(4'd1);
      card(4'd13);
      chk("bj_total", 32'(hand_total_o), 32'd21);
      chk("bj_soft", 32'(soft_o), 32'd1);
      chk("bj_flag", 32'(blackjack_o), 32'd1);
      chk("bj_count", 32'(card_count_o), 32'd2);
      chk("model_bj_total", 32'(m_total()), 32'd21);

      // 10, 6, 9: bust, further hits refused.
      new_hand();
      card(4'd10);
      card(4'd6);
      card(4'd9);
      chk("bust_total", 32'(hand_total_o), 32'd25);
      chk("bust_flag", 32'(bust_o), 32'd1);
      do_hit(4'd2);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bust_no_req", 32'(req_card_o), 32'd0);
         @(negedge clk_i);
      end

      // Silent generator: timeout error.
      new_hand();
      gen_silent = 1'b1;
      do_hit(4'd3);
      repeat (TMO + 2) @(negedge clk_i);
      #1;
      chk("tmo_error", 32'(error_o), 32'd1);
      chk("tmo_req", 32'(req_card_o), 32'd0);
      chk("tmo_busy", 32'(busy_o), 32'd0);
      gen_silent = 1'b0;
      new_hand();
      #1;
      chk("tmo_cleared", 32'(error_o), 32'd0);

      // Trailing SEND must not add a second card.
      card(4'd5);
      repeat (3) @(negedge clk_i);
      #1;
      chk("trail_count", 32'(card_count_o), 32'd1);
      chk("trail_total", 32'(hand_total_o), 32'd5);

      // Soft hand turning hard.
      new_hand();
      card(4'd1);
      card(4'd1);
      card(4'd9);
      chk("soft21_total", 32'(hand_total_o), 32'd21);
      chk("soft21_soft", 32'(soft_o), 32'd1);
      card(4'd5);
      chk("hard16_total", 32'(hand_total_o), 32'd16);
      chk("hard16_soft", 32'(soft_o), 32'd0);
      chk("model_hard16", 32'(m_total()), 32'd16);

      // new_hand while a request is in flight.
      new_hand();
      card(4'd4);
      do_hit(4'd7);
      new_hand_i = 1'b1;
      @(negedge clk_i);
      #1;
      new_hand_i = 1'b0;
      chk("nh_req", 32'(req_card_o), 32'd0);
      chk("nh_total", 32'(hand_total_o), 32'd0);
      chk("nh_count", 32'(card_count_o), 32'd0);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         #1;
         if (card_done_o) dones++;
      end
      chk("nh_no_done", 32'(dones), 32'd0);

      // Asynchronous reset while a request is in flight.
      card(4'd8);
      do_hit(4'd7);
      #2;
      rst_i = 1'b0;
      #1;
      chk("rst_req_async", 32'(req_card_o), 32'd0);
      chk("rst_busy_async", 32'(busy_o), 32'd0);
      chk("rst_total_async", 32'(hand_total_o), 32'd0);
      chk("rst_count_async", 32'(card_count_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         #1;
         if (card_done_o) dones++;
      end
      chk("rst_no_done", 32'(dones), 32'd0);

      // Randomized play, including hit and new_hand on the same edge.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_i);
         hit_i      = ($urandom_range(99) < 40);
         new_hand_i = ($urandom_range(99) < 3);
         card_i     = 4'($urandom_range(13, 1));
      end
      @(negedge clk_i);
      hit_i = 1'b0;
      new_hand_i = 1'b0;
      repeat (3) @(negedge clk_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hand_card_requester.md
# hand_card_requester

Initiator side of the card-request handshake in the blackjack datapath: on a player or dealer "hit", it raises a card request toward the seed_random card generator and waits for the generator's SEND response. It then captures the card value, maps it to blackjack points and maintains the hand state: hard sum, soft total, card count, bust and blackjack. It sits between the game FSM and each seed_random generator instance, one instance per hand.

## Interface
- TIMEOUT_CYCLES, 16: WAIT cycles allowed without a generator response before error.
- MAX_CARDS, 11: hand size limit; further hits are refused.
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- hit_i  in  1  request one card; sampled only in IDLE.
- new_hand_i  in  1  clear the hand and abort any request in flight.
- card_valid_i  in  1  generator state output (1 = SEND).
- card_i  in  4  card rank: 1 = ace, 2..10, 11..13 = J/Q/K; 0, 14 and 15 are invalid.
- req_card_o  out  1  card request to generator (its req_card_state input).
- busy_o  out  1  high when not in IDLE.
- card_done_o  out  1  one-cycle pulse when the totals have been updated.
- hand_total_o  out  5  best total: hard_sum+10 if an ace is held and hard_sum ≤ 11, else hard_sum.
- soft_o  out  1  hand_total_o currently counts one ace as 11.
- card_count_o  out  4  cards in hand.
- bust_o  out  1  hard_sum > 21.
- blackjack_o  out  1  card_count = 2 and hand_total = 21.
- error_o  out  1  sticky; set on timeout or invalid rank, cleared by new_hand_i.

## Operation
- FSM states: IDLE, REQ, ADD, DONE.
  - IDLE: on hit_i, with no bust, card_count < MAX_CARDS and no error, go to REQ. Otherwise hit_i is ignored.
  - REQ: req_card_o = 1 and the timeout counter runs. When card_valid_i is high, latch card_i, drop req, go to ADD. On timeout, set error_o, drop req, go to IDLE.
  - ADD: update hard_sum and ace flag, increment card_count, go to DONE. An invalid rank sets error_o and leaves the totals unchanged.
  - DONE: pulse card_done_o, go to IDLE.
- Point mapping: ace → 1 (sets ace flag); 2..10 → face value; 11..13 → 10.
- hard_sum width is 5 bits. The maximum reachable value is 21+10 = 31, so no wrap occurs.
- card_valid_i is accepted only in REQ. The generator's output is registered and produces one trailing SEND cycle after req drops. That trailing cycle arrives while in ADD and is ignored.
- new_hand_i has priority over everything. From any state, the next edge gives IDLE with all hand registers, error_o and req_card_o cleared.
- Reset (asynchronous, any state): IDLE, all outputs 0, hand_total_o = 0.

## Timing
- hit_i sampled at edge k → req_card_o high after edge k.
- Generator registers req at edge k+1 → card_valid_i high after k+1.
- card_valid_i sampled at k+2 → card latched and req_card_o low after k+2.
- Totals, count, bust, soft and blackjack are all updated at edge k+3. card_done_o is high during the cycle after k+3.
- Back to IDLE at k+4, so the earliest next hit is sampled at k+4. Minimum hit-to-done latency is 3 cycles.
- Timeout: error_o sets TIMEOUT_CYCLES edges after entering REQ if card_valid_i never rises.
- hit_i and new_hand_i on the same edge: new_hand_i wins and no request is issued.
- All outputs are registered. The hand flags are combinational only from the hand registers.

## Structure
- Shared package blackjack_pkg holds:
  - the FSM state encoding;
  - CARD_W = 4 and TOTAL_W = 5;
  - rank constants ACE = 1 and KING = 13;
  - BLACKJACK = 21;
  - function card_points(rank).
- Sub-module hand_score_calc: combinational. Takes hard_sum, ace flag and count; produces hand_total, soft, bust and blackjack.

## Test plan
- Reset, then hits with ranks 1 and 13 → after the second card_done_o: hand_total_o = 21, soft_o = 1, blackjack_o = 1, card_count_o = 2.
- Hits 10, 6, 9 → hand_total_o = 25, bust_o = 1. A further hit_i is ignored: req_card_o stays 0.
- Generator model held silent for 16 cycles → error_o = 1, req_card_o = 0, state IDLE. Then new_hand_i → error_o = 0.
- Generator model asserting card_valid_i for 2 cycles (trailing SEND) on rank 5 → card_count_o increments by exactly 1, hand_total_o = 5.
- Cards 1, 1, 9 → hand_total_o = 21, soft_o = 1. Next card 5 → hand_total_o = 16, soft_o = 0.
- new_hand_i and, separately, rst_i asserted while in REQ → req_card_o = 0 next edge (immediately for rst_i), all totals 0, no card_done_o pulse.
